// File: rtl/skolem_pkg.sv
// Shared types and constants for the sequential XOR-constraint Skolem engine.
package skolem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // cfg_mode encoding that selects the all-ones free-bit fill
  localparam logic FILL_ONES = 1'b0;

  function automatic int nbeat(input int n_in, input int slice);
    return (n_in + slice - 1) / slice;
  endfunction

endpackage

// File: rtl/skolem_lfsr.sv
// 16-bit Galois LFSR supplying free witness bits; only the low OUT_W bits leave the block.
module skolem_lfsr
  import skolem_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  output logic [OUT_W-1:0] bits
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (advance) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign bits = state[OUT_W-1:0];

endmodule

// File: rtl/xor_skolem_engine.sv
// Sequential XOR Skolem engine: folds x into a parity bit over several beats, then
// emits a witness y whose pivot bit makes XOR(x) ^ XOR(y) equal the requested target.
module xor_skolem_engine
  import skolem_pkg::*;
#(
  parameter int          N_IN      = 6,
  parameter int          N_OUT     = 10,
  parameter int          PIVOT     = 0,
  parameter int          SLICE     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_target,
  input  logic             cfg_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_y,
  output logic [CNT_W-1:0] sol_count,
  output logic             chk_err
);

  localparam int NBEAT = nbeat(N_IN, SLICE);
  localparam int BW    = $clog2(NBEAT + 1);

  state_t            state, state_nx;
  logic [N_IN-1:0]   x_reg, x_sh;
  logic              target_reg, mode_reg, acc;
  logic [BW-1:0]     beat;
  logic [N_OUT-2:0]  lfsr_bits, free;
  logic [N_OUT-1:0]  y_nx;
  logic              accept, deliver, last_beat, lfsr_adv;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign last_beat = (beat == BW'(NBEAT));
  assign lfsr_adv  = deliver && (mode_reg != FILL_ONES);

  skolem_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (N_OUT - 1)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (1'b0),
    .advance (lfsr_adv),
    .bits    (lfsr_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = ACCUM;
      ACCUM:   if (last_beat) state_nx = EMIT;
      EMIT:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Witness assembly: free bits fill the non-pivot slots in ascending order
  always_comb begin : place
    int k;
    k    = 0;
    free = (mode_reg == FILL_ONES) ? '1 : lfsr_bits;
    y_nx = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (j != PIVOT) begin
        y_nx[j] = free[k];
        k++;
      end
    end
    y_nx[PIVOT] = target_reg ^ acc ^ (^free);
  end

  // Transaction data; the right shift zero-pads the final partial slice
  always_ff @(posedge clk) begin
    if (accept) begin
      x_reg      <= in_x;
      x_sh       <= in_x;
      target_reg <= cfg_target;
      mode_reg   <= cfg_mode;
      acc        <= 1'b0;
    end else if (state == ACCUM && !last_beat) begin
      acc  <= acc ^ (^x_sh[SLICE-1:0]);
      x_sh <= x_sh >> SLICE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      sol_count <= '0;
      chk_err   <= 1'b0;
    end else begin
      if (accept) begin
        beat <= '0;
      end else if (state == ACCUM && !last_beat) begin
        beat <= beat + 1'b1;
      end

      if (state == ACCUM && last_beat) begin
        out_valid <= 1'b1;
        out_y     <= y_nx;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end

      if (deliver && (sol_count != '1)) begin
        sol_count <= sol_count + 1'b1;
      end

      if (state == EMIT && (((^x_reg) ^ (^out_y)) != target_reg)) begin
        chk_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xor_skolem_engine.sv
// Scoreboard bench for xor_skolem_engine: directed cases followed by random traffic with backpressure.
module tb_xor_skolem_engine;

  localparam int          N_IN  = 6;
  localparam int          N_OUT = 10;
  localparam int          PIVOT = 0;
  localparam int          SLICE = 2;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_target = 1'b0;
  logic             cfg_mode = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  in_x = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N_OUT-1:0] out_y;
  logic [CNT_W-1:0] sol_count;
  logic             chk_err;

  xor_skolem_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .PIVOT(PIVOT), .SLICE(SLICE),
    .LFSR_SEED(SEED), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_target(cfg_target), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .sol_count(sol_count), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail = 0;
  int               handshakes = 0;
  logic [15:0]      lfsr_m = SEED;
  logic [N_OUT-1:0] exp_q[$];
  logic [N_IN-1:0]  x_q[$];
  logic             t_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [N_OUT-1:0] model_y(input logic [N_IN-1:0] x, input logic tgt,
                                               input logic mode);
    logic [N_OUT-2:0] fr;
    logic [N_OUT-1:0] y;
    int k;
    fr = mode ? lfsr_m[N_OUT-2:0] : '1;
    y  = '0;
    k  = 0;
    for (int j = 0; j < N_OUT; j++) begin
      if (j != PIVOT) begin
        y[j] = fr[k];
        k++;
      end
    end
    y[PIVOT] = tgt ^ (^x) ^ (^fr);
    return y;
  endfunction

  task automatic push_exp(input logic [N_IN-1:0] x, input logic tgt, input logic mode);
    exp_q.push_back(model_y(x, tgt, mode));
    x_q.push_back(x);
    t_q.push_back(tgt);
    if (mode) lfsr_m = lfsr_step(lfsr_m);
  endtask

  task automatic send(input logic [N_IN-1:0] x, input logic tgt, input logic mode);
    int guard = 0;
    in_x = x; cfg_target = tgt; cfg_mode = mode; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
    push_exp(x, tgt, mode);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!out_valid) check("out_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic recv(input int stall);
    logic [N_OUT-1:0] want;
    logic [N_IN-1:0]  wx;
    logic             wt;
    wait_valid();
    if (!out_valid) return;
    out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1'b0, 1'b1);
      return;
    end
    want = exp_q.pop_front();
    wx   = x_q.pop_front();
    wt   = t_q.pop_front();
    check("y", out_y, want);
    check("parity", (^wx) ^ (^out_y), wt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    handshakes++;
    check("valid_drop", out_valid, 1'b0);
  endtask

  initial begin
    logic [N_OUT-1:0] held;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_y", out_y, '0);
    check("rst_sol_count", sol_count, '0);
    check("rst_chk_err", chk_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, target 0, x=000001, with latency check
    in_x = 6'b000001; cfg_target = 1'b0; cfg_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t1_busy", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_latency_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check("t1_latency_valid", out_valid, 1'b1);
    check("t1_y", out_y, 10'b1111111110);
    check("t1_chk_err", chk_err, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    handshakes++;
    check("t1_valid_drop", out_valid, 1'b0);
    check("t1_sol_count", sol_count, 16'd1);
    check("t1_y_retained", out_y, 10'b1111111110);

    // Mode 0, target 1, x=0
    send(6'b000000, 1'b1, 1'b0);
    recv(0);
    check("t2_y", out_y, 10'b1111111110);

    // Backpressure with a pending back-to-back request
    send(6'b000011, 1'b0, 1'b0);
    wait_valid();
    held = out_y;
    check("stall_y", held, 10'b1111111111);
    in_x = 6'b000001; cfg_target = 1'b0; cfg_mode = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1'b1);
      check("stall_hold", out_y, held);
      check("stall_in_ready", in_ready, 1'b0);
    end
    check("stall_y_model", out_y, exp_q.pop_front());
    void'(x_q.pop_front());
    void'(t_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    handshakes++;
    check("stall_drop", out_valid, 1'b0);
    check("b2b_idle", in_ready, 1'b1);
    push_exp(6'b000001, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accepted", in_ready, 1'b0);
    recv(0);
    check("b2b_y", out_y, 10'b1111111110);
    check("stall_sol_count", sol_count, CNT_W'(handshakes));

    // Reset in ACCUM, with mode 1 so the LFSR would otherwise have advanced
    send(6'b101101, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_y", out_y, '0);
    check("arst_sol_count", sol_count, '0);
    check("arst_chk_err", chk_err, 1'b0);
    exp_q.delete(); x_q.delete(); t_q.delete();
    lfsr_m = SEED;
    handshakes = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_emit", out_valid, 1'b0);

    // Mode 1 from seed, then from the advanced LFSR
    send(6'b101101, 1'b0, 1'b1);
    recv(0);
    check("lfsr_seed_y", out_y, 10'b0111000010);
    send(6'b000000, 1'b0, 1'b1);
    recv(1);
    check("lfsr_adv_y", out_y, 10'b0011100001);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      send(N_IN'($urandom), 1'($urandom), 1'($urandom));
      recv(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    check("final_sol_count", sol_count, CNT_W'(handshakes));
    check("final_chk_err", chk_err, 1'b0);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
